// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS decode stage: opcode and funct encodings,
// ALU control codes, and the control bundle produced by the control ROM.
// No ports; imported by mips_ctrl_rom and mips_decode_stage.

package mips_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    // ALU control codes driven to the execute stage
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_MUL = 4'b0011,
        ALU_DIV = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_t;

    // Everything the decode stage derives from opcode/funct alone.
    // zero_ext, uses_rs and uses_rt stay internal to the stage; the rest
    // are registered straight onto the output ports.
    typedef struct packed {
        alu_op_t alu_ctr;
        logic    reg_dst;
        logic    reg_wrt;
        logic    mem_read;
        logic    mem_wrt;
        logic    mem_reg;
        logic    alu_src;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    illegal;
        logic    zero_ext;
        logic    uses_rs;
        logic    uses_rt;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_rom.sv
// mips_ctrl_rom
// Purely combinational opcode/funct to control-bundle lookup.
// Ports:
//   opcode  in  6       inst[31:26]
//   funct   in  6       inst[5:0], only meaningful for R-type
//   ctrl    out ctrl_t  decoded control bundle

module mips_ctrl_rom
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Every field starts cleared; rs counts as read by everything except J,
    // including unknown opcodes, so hazard checks stay conservative.
    always_comb begin
        ctrl         = '0;
        ctrl.alu_ctr = ALU_AND;
        ctrl.uses_rs = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst = 1'b1;
                ctrl.reg_wrt = 1'b1;
                ctrl.uses_rt = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_ctr = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctr = ALU_SUB;
                    FN_AND:  ctrl.alu_ctr = ALU_AND;
                    FN_OR:   ctrl.alu_ctr = ALU_OR;
                    FN_SLT:  ctrl.alu_ctr = ALU_SLT;
                    FN_MUL:  ctrl.alu_ctr = ALU_MUL;
                    FN_DIV:  ctrl.alu_ctr = ALU_DIV;
                    default: begin
                        // Unknown funct must never write the register file
                        ctrl.alu_ctr = ALU_ADD;
                        ctrl.illegal = 1'b1;
                        ctrl.reg_wrt = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alu_ctr  = ALU_ADD;
                ctrl.alu_src  = 1'b1;
                ctrl.reg_wrt  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mem_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_ctr = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.mem_wrt = 1'b1;
                ctrl.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_ctr = ALU_SUB;
                ctrl.branch  = 1'b1;
                ctrl.uses_rt = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_ctr   = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_ctr = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.reg_wrt = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_ctr = ALU_SLT;
                ctrl.alu_src = 1'b1;
                ctrl.reg_wrt = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_ctr  = ALU_AND;
                ctrl.alu_src  = 1'b1;
                ctrl.reg_wrt  = 1'b1;
                ctrl.zero_ext = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_ctr  = ALU_OR;
                ctrl.alu_src  = 1'b1;
                ctrl.reg_wrt  = 1'b1;
                ctrl.zero_ext = 1'b1;
            end
            OP_J: begin
                ctrl.jump    = 1'b1;
                ctrl.uses_rs = 1'b0;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage
// Registered instruction-decode stage with a one-entry valid/ready output
// register, load-use hazard bubbling, flush, and illegal-opcode flagging.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   flush                    drop held instruction and hazard state
//   in_valid/in_ready/inst   upstream handshake and instruction word
//   out_valid/out_ready      downstream handshake
//   alu_ctr .. illegal       registered control outputs
//   rs, rt, rd, shamt, funct registered instruction fields
//   imm_ext, jaddr           extended immediate, jump target field
//   stall_cnt                saturating count of inserted bubbles

module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_ctr,
    output logic              reg_dst,
    output logic              reg_wrt,
    output logic              mem_read,
    output logic              mem_wrt,
    output logic              mem_reg,
    output logic              alu_src,
    output logic              branch,
    output logic              branch_ne,
    output logic              jump,
    output logic              illegal,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_ext,
    output logic [25:0]       jaddr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [5:0]        in_op;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [DATA_W-1:0] in_imm;
    ctrl_t             in_ctrl;
    logic              lw_pend;
    logic [REG_AW-1:0] lw_rt;
    logic              hazard;
    logic              out_free;

    assign in_op = inst[31:26];
    assign in_rs = REG_AW'(inst[25:21]);
    assign in_rt = REG_AW'(inst[20:16]);

    mips_ctrl_rom u_ctrl_rom (
        .opcode (in_op),
        .funct  (inst[5:0]),
        .ctrl   (in_ctrl)
    );

    assign in_imm = in_ctrl.zero_ext ? {{(DATA_W-16){1'b0}}, inst[15:0]}
                                     : {{(DATA_W-16){inst[15]}}, inst[15:0]};

    // lw_rt is never zero while lw_pend is set, so $0 readers never stall
    assign hazard = in_valid & lw_pend &
                    ((in_ctrl.uses_rs & (in_rs == lw_rt)) |
                     (in_ctrl.uses_rt & (in_rt == lw_rt)));

    assign out_free = !out_valid | out_ready;
    assign in_ready = out_free & !hazard & !flush;

    // Priority: reset, flush, hold, hazard bubble, accept. The bubble
    // clears lw_pend so the dependent instruction goes through next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lw_pend   <= 1'b0;
            lw_rt     <= '0;
            stall_cnt <= '0;
            alu_ctr   <= '0;
            reg_dst   <= 1'b0;
            reg_wrt   <= 1'b0;
            mem_read  <= 1'b0;
            mem_wrt   <= 1'b0;
            mem_reg   <= 1'b0;
            alu_src   <= 1'b0;
            branch    <= 1'b0;
            branch_ne <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            shamt     <= '0;
            funct     <= '0;
            imm_ext   <= '0;
            jaddr     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            lw_pend   <= 1'b0;
        end else if (!out_free) begin
            out_valid <= out_valid;
        end else if (hazard) begin
            out_valid <= 1'b0;
            lw_pend   <= 1'b0;
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else if (in_valid) begin
            out_valid <= 1'b1;
            lw_pend   <= (in_op == OP_LW) && (in_rt != '0);
            lw_rt     <= in_rt;
            alu_ctr   <= in_ctrl.alu_ctr;
            reg_dst   <= in_ctrl.reg_dst;
            reg_wrt   <= in_ctrl.reg_wrt;
            mem_read  <= in_ctrl.mem_read;
            mem_wrt   <= in_ctrl.mem_wrt;
            mem_reg   <= in_ctrl.mem_reg;
            alu_src   <= in_ctrl.alu_src;
            branch    <= in_ctrl.branch;
            branch_ne <= in_ctrl.branch_ne;
            jump      <= in_ctrl.jump;
            illegal   <= in_ctrl.illegal;
            rs        <= in_rs;
            rt        <= in_rt;
            rd        <= REG_AW'(inst[15:11]);
            shamt     <= inst[10:6];
            funct     <= inst[5:0];
            imm_ext   <= in_imm;
            jaddr     <= inst[25:0];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage
// Self-checking bench for mips_decode_stage: directed scenarios followed by
// a randomized phase, compared against an instruction-level reference model.

module tb_mips_decode_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] inst;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_ctr;
    logic              reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg;
    logic              alu_src, branch, branch_ne, jump, illegal;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [25:0]       jaddr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [9:0]        dut_flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_inst;
    bit          m_lw_pend;
    logic [4:0]  m_lw_rt;
    int          m_stall;
    int          accepted;
    int          dropped;
    int          dut_delivered;

    logic [63:0] snap_fields;
    int          saved_stall;

    mips_decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctr   (alu_ctr),
        .reg_dst   (reg_dst),
        .reg_wrt   (reg_wrt),
        .mem_read  (mem_read),
        .mem_wrt   (mem_wrt),
        .mem_reg   (mem_reg),
        .alu_src   (alu_src),
        .branch    (branch),
        .branch_ne (branch_ne),
        .jump      (jump),
        .illegal   (illegal),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm_ext   (imm_ext),
        .jaddr     (jaddr),
        .stall_cnt (stall_cnt)
    );

    assign dut_flags = {reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg,
                        alu_src, branch, branch_ne, jump, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {alu[3:0], reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg,
    // alu_src, branch, branch_ne, jump, illegal} for one instruction word.
    function automatic logic [13:0] ref_ctrl(input logic [31:0] i);
        logic [3:0] alu;
        logic dst, wrt, mrd, mwr, mreg, asrc, br, bne, jmp, ill;
        {alu, dst, wrt, mrd, mwr, mreg, asrc, br, bne, jmp, ill} = '0;
        case (i[31:26])
            6'h00: begin
                dst = 1; wrt = 1;
                case (i[5:0])
                    6'h20: alu = 4'd2;
                    6'h22: alu = 4'd6;
                    6'h24: alu = 4'd0;
                    6'h25: alu = 4'd1;
                    6'h2A: alu = 4'd7;
                    6'h18: alu = 4'd3;
                    6'h1A: alu = 4'd4;
                    default: begin alu = 4'd2; ill = 1; wrt = 0; end
                endcase
            end
            6'h23: begin alu = 4'd2; asrc = 1; wrt = 1; mrd = 1; mreg = 1; end
            6'h2B: begin alu = 4'd2; asrc = 1; mwr = 1; end
            6'h04: begin alu = 4'd6; br = 1; end
            6'h05: begin alu = 4'd6; br = 1; bne = 1; end
            6'h08: begin alu = 4'd2; asrc = 1; wrt = 1; end
            6'h0A: begin alu = 4'd7; asrc = 1; wrt = 1; end
            6'h0C: begin alu = 4'd0; asrc = 1; wrt = 1; end
            6'h0D: begin alu = 4'd1; asrc = 1; wrt = 1; end
            6'h02: jmp = 1;
            default: ill = 1;
        endcase
        return {alu, dst, wrt, mrd, mwr, mreg, asrc, br, bne, jmp, ill};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        if (i[31:26] == 6'h0C || i[31:26] == 6'h0D)
            return {16'h0000, i[15:0]};
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
        logic [5:0] op;
        bit rs_hit, rt_hit;
        op = i[31:26];
        rs_hit = (op != 6'h02) && (i[25:21] == r);
        rt_hit = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05)
                 && (i[20:16] == r);
        return rs_hit || rt_hit;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] f_rs, f_rt, f_rd, f_sh;
        case ($urandom_range(0, 11))
            0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;  3: op = 6'h04;
            4: op = 6'h05;  5: op = 6'h08;  6: op = 6'h0A;  7: op = 6'h0C;
            8: op = 6'h0D;  9: op = 6'h02; 10: op = 6'h23;
            default: op = 6'($urandom_range(0, 63));
        endcase
        case ($urandom_range(0, 7))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h2A; 5: fn = 6'h18; 6: fn = 6'h1A;
            default: fn = 6'($urandom_range(0, 63));
        endcase
        f_rs = 5'($urandom_range(0, 3));
        f_rt = 5'($urandom_range(0, 3));
        f_rd = 5'($urandom_range(0, 31));
        f_sh = 5'($urandom_range(0, 31));
        return {op, f_rs, f_rt, f_rd, f_sh, fn};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_fields(input string tag, input logic [31:0] i);
        logic [13:0] c;
        c = ref_ctrl(i);
        check_output({tag, ":alu_ctr"}, 64'(alu_ctr), 64'(c[13:10]));
        check_output({tag, ":flags"}, 64'(dut_flags), 64'(c[9:0]));
        check_output({tag, ":regs"}, 64'({rs, rt, rd}),
                     64'({i[25:21], i[20:16], i[15:11]}));
        check_output({tag, ":shamt_funct"}, 64'({shamt, funct}), 64'(i[10:0]));
        check_output({tag, ":imm_ext"}, 64'(imm_ext), 64'(ref_imm(i)));
        check_output({tag, ":jaddr"}, 64'(jaddr), 64'(i[25:0]));
    endtask

    // Drive one cycle of inputs from the falling edge, check in_ready before
    // the rising edge, advance the model, then check outputs at the next
    // falling edge.
    task automatic apply_stimulus(input bit v, input logic [31:0] ins,
                                  input bit ordy, input bit fl);
        bit exp_hazard;
        bit exp_ready;
        in_valid  = v;
        inst      = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_hazard = v && m_lw_pend && reads_reg(ins, m_lw_rt);
        exp_ready  = (!m_valid || ordy) && !exp_hazard && !fl;
        check_output("in_ready", 64'(in_ready), 64'(exp_ready));
        if (out_valid && out_ready) dut_delivered++;
        @(posedge clk);
        if (fl) begin
            if (m_valid && !ordy) dropped++;
            m_valid   = 0;
            m_lw_pend = 0;
        end else if (m_valid && !ordy) begin
            m_valid = 1;
        end else if (exp_hazard) begin
            m_valid   = 0;
            m_lw_pend = 0;
            if (m_stall < (1 << CNT_W) - 1) m_stall++;
        end else if (v) begin
            m_valid   = 1;
            m_inst    = ins;
            m_lw_pend = (ins[31:26] == 6'h23) && (ins[20:16] != 5'd0);
            m_lw_rt   = ins[20:16];
            accepted++;
        end else begin
            m_valid = 0;
        end
        @(negedge clk);
        check_output("out_valid", 64'(out_valid), 64'(m_valid));
        check_output("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (m_valid) check_fields("decode", m_inst);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0;
        m_valid = 0; m_inst = '0; m_lw_pend = 0; m_lw_rt = '0; m_stall = 0;
        accepted = 0; dropped = 0; dut_delivered = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_output("reset:out_valid", 64'(out_valid), 64'd0);
        check_output("reset:stall_cnt", 64'(stall_cnt), 64'd0);
        check_output("reset:ctrl", 64'({alu_ctr, dut_flags}), 64'd0);
        check_output("reset:fields", 64'({rs, rt, rd, shamt, funct, jaddr}), 64'd0);
        check_output("reset:imm_ext", 64'(imm_ext), 64'd0);

        // Streaming ADD, ORI, J at full throughput
        apply_stimulus(1, 32'h00221820, 1, 0);
        check_output("stream:add_alu", 64'(alu_ctr), 64'h2);
        apply_stimulus(1, 32'h3443FFFF, 1, 0);
        check_output("stream:ori_imm", 64'(imm_ext), 64'h0000FFFF);
        check_output("stream:ori_alu", 64'(alu_ctr), 64'h1);
        apply_stimulus(1, 32'h08000010, 1, 0);
        check_output("stream:j_jump", 64'(jump), 64'd1);
        apply_stimulus(1, 32'h2022FFFF, 1, 0);
        check_output("stream:addi_imm", 64'(imm_ext), 64'hFFFFFFFF);

        // Load-use: LW $3 then ADD reading $3 gives exactly one bubble
        apply_stimulus(1, 32'h8C230004, 1, 0);
        apply_stimulus(1, 32'h00630820, 1, 0);
        check_output("loaduse:bubble", 64'(out_valid), 64'd0);
        check_output("loaduse:stall_cnt", 64'(stall_cnt), 64'd1);
        apply_stimulus(1, 32'h00630820, 1, 0);
        check_output("loaduse:add_out", 64'({out_valid, rd}), 64'({1'b1, 5'd1}));

        // LW $0 then a reader of $0: no bubble
        apply_stimulus(1, 32'h8C200004, 1, 0);
        apply_stimulus(1, 32'h00000820, 1, 0);
        check_output("lw_r0:no_bubble", 64'(out_valid), 64'd1);

        // Output hold for three cycles with a stalled downstream
        apply_stimulus(1, 32'h2022FFFF, 1, 0);
        snap_fields = {alu_ctr, dut_flags, rs, rt, rd, shamt, funct, 24'd0};
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 32'h00221820, 0, 0);
            check_output("hold:stable",
                         {alu_ctr, dut_flags, rs, rt, rd, shamt, funct, 24'd0},
                         snap_fields);
            check_output("hold:imm", 64'(imm_ext), 64'hFFFFFFFF);
        end
        apply_stimulus(1, 32'h00221820, 1, 0);
        check_output("hold:next", 64'(alu_ctr), 64'h2);

        // Illegal opcode and illegal R-type funct
        apply_stimulus(1, 32'hFC000000, 1, 0);
        check_output("illegal_op", 64'({illegal, reg_wrt, mem_wrt, mem_read}), 64'b1000);
        apply_stimulus(1, 32'h00000007, 1, 0);
        check_output("illegal_fn", 64'({illegal, reg_wrt}), 64'b10);

        // Flush during a stalled LW/ADD pair; re-presented ADD goes through
        apply_stimulus(1, 32'h8C230004, 1, 0);
        saved_stall = m_stall;
        apply_stimulus(1, 32'h00630820, 1, 1);
        check_output("flush:out_valid", 64'(out_valid), 64'd0);
        check_output("flush:stall_kept", 64'(stall_cnt), 64'(saved_stall));
        apply_stimulus(1, 32'h00630820, 1, 0);
        check_output("flush:readd", 64'(out_valid), 64'd1);

        // Drive enough load-use pairs to saturate the bubble counter
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1, 32'h8C230004, 1, 0);
            apply_stimulus(1, 32'h00630820, 1, 0);
            apply_stimulus(1, 32'h00630820, 1, 0);
        end
        check_output("stall:saturated", 64'(stall_cnt), 64'h7);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            apply_stimulus($urandom_range(0, 3) != 0, rand_inst(),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        for (int k = 0; k < 4; k++) apply_stimulus(0, 32'h0, 1, 0);
        check_output("scoreboard:delivered", 64'(dut_delivered), 64'(accepted - dropped));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
